tp_adc_responder: RTL and testbench
===================================

TP_ADC_RESPONDER -- requirements
Module: tp_adc_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth on TP_SCLK_I, TP_SS_N_I and TP_MOSI_I.
REQ-002 Parameter X_ADDR, default 3'b101: command channel bits that select X.
REQ-003 Parameter Y_ADDR, default 3'b001: command channel bits that select Y.
REQ-004 Clock  input  1  system clock; all logic is on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 TP_SCLK_I  input  1  serial clock driven by the touch panel controller.
REQ-007 TP_SS_N_I  input  1  active-low select; a transaction is live while it is low.
REQ-008 TP_MOSI_I  input  1  command bits, MSB first, sampled on SCLK rising edges.
REQ-009 TP_MISO_O  output  1  conversion bits, MSB first, updated on SCLK falling edges.
REQ-010 TP_BUSY_O  output  1  conversion-in-progress flag.
REQ-011 TP_PENIRQ_N_O  output  1  active-low pen-down interrupt.
REQ-012 Touch_I  input  1  emulated pen-down level.
REQ-013 X_Value_I / Y_Value_I  input  12 each  emulated conversion results.
REQ-014 Cmd_Valid_O  output  1  one-cycle pulse when a command byte is accepted.
REQ-015 Cmd_O  output  8  last accepted command byte.

Function
REQ-016 Inputs SHALL pass through SYNC_STAGES flops; edge detection SHALL use the synchronised SCLK; internal edge latency is SYNC_STAGES+1 Clock cycles.
REQ-017 SCLK high and low phases SHALL each be at least 4 Clock cycles; shorter phases are out of scope.
REQ-018 FSM states: IDLE, CMD, BUSY, DATA.
REQ-019 IDLE -> CMD when synchronised SS_N falls.
REQ-020 In CMD, rising edges with MOSI=0 and no bits captured SHALL be ignored (leading zeros); the first 1 is the start bit.
REQ-021 CMD SHALL shift 8 bits including the start bit; on the 8th rising edge, Cmd_O SHALL load the byte and Cmd_Valid_O SHALL pulse for 1 cycle.
REQ-022 On the 8th rising edge, the responder SHALL snapshot the result: X_Value_I if bits[6:4]==X_ADDR, Y_Value_I if bits[6:4]==Y_ADDR, else 12'h000; changes to the inputs after the snapshot SHALL have no effect.
REQ-023 Bit 3 of the command is MODE: 0 gives 12 data bits, 1 gives 8 data bits (snapshot[11:4]). Bits[1:0] are PD.
REQ-024 CMD -> BUSY: TP_BUSY_O SHALL rise on the first falling edge after the 8th rising edge, and fall on the next falling edge, which also drives the data MSB on TP_MISO_O; the state is then DATA.
REQ-025 DATA SHALL present one further bit per falling edge until 12 (or 8) bits are out, then drive 0 and return to CMD, ready for a new start bit with SS_N still low.
REQ-026 TP_MISO_O SHALL be 0 outside DATA.
REQ-027 Synchronised SS_N rising in any state SHALL force IDLE next cycle: MISO 0, BUSY 0, bit counters cleared, and Cmd_O retained.
REQ-028 TP_PENIRQ_N_O (registered) SHALL be ~Touch_I when state==IDLE and the last PD==2'b00; otherwise 1.
REQ-029 If SS_N rises and an SCLK edge arrives in the same cycle, SS_N has priority and the edge is discarded.

Reset
REQ-030 While Reset is high, outputs SHALL be: TP_MISO_O=0, TP_BUSY_O=0, TP_PENIRQ_N_O=1, Cmd_Valid_O=0, Cmd_O=8'h00. State SHALL be IDLE, synchronisers 1 for SCLK/SS_N and 0 for MOSI, and the stored PD SHALL be 2'b00.
REQ-031 Reset asserted mid-transaction SHALL take effect immediately, independent of Clock; after release, the responder SHALL wait for a fresh SS_N falling edge.

Verification
REQ-032 Touch_I=1, release Reset -> TP_PENIRQ_N_O goes 1 to 0 within SYNC_STAGES+2 cycles; Touch_I=0 -> returns to 1.
REQ-033 Send 8'h90 with Y_Value_I=12'hA5C -> Cmd_Valid_O pulses once, Cmd_O=8'h90, BUSY high for exactly one SCLK period, MISO on the next 12 rising edges reads 1010_0101_1100.
REQ-034 Send 8'hD0 with X_Value_I=12'h3F1, then change X_Value_I to 12'h000 after bit 3 -> MISO reads 0011_1111_0001.
REQ-035 Send 8'hD8 with X_Value_I=12'hC3A -> 8 bits 1100_0011, then MISO 0.
REQ-036 Send 3 zero bits then 8'h90 -> accepted as 8'h90. Raise SS_N after 5 data bits -> BUSY 0, MISO 0, IDLE. The next 8'h90 transaction completes normally.
REQ-037 Send 8'h91 with Touch_I=1, then SS_N high -> TP_PENIRQ_N_O stays 1; send 8'h90 -> it returns to 0 after SS_N rises.

Source files
------------

// File: rtl/tp_adc_responder_if.sv
// Touch panel serial link between the panel controller (master) and
// the emulated ADC (slave): serial clock, select, command in, data out,
// busy flag and pen-down interrupt.
interface tp_adc_responder_if;
   logic TP_SCLK_I;
   logic TP_SS_N_I;
   logic TP_MOSI_I;
   logic TP_MISO_O;
   logic TP_BUSY_O;
   logic TP_PENIRQ_N_O;

   modport master (
      output TP_SCLK_I,
      output TP_SS_N_I,
      output TP_MOSI_I,
      input  TP_MISO_O,
      input  TP_BUSY_O,
      input  TP_PENIRQ_N_O
   );

   modport slave (
      input  TP_SCLK_I,
      input  TP_SS_N_I,
      input  TP_MOSI_I,
      output TP_MISO_O,
      output TP_BUSY_O,
      output TP_PENIRQ_N_O
   );
endinterface

// File: rtl/tp_adc_responder.sv
// Emulated touch-panel ADC. It accepts an 8-bit command (start bit
// first, leading zeros skipped), snapshots X or Y, raises BUSY for one
// SCLK period and then shifts out 12 or 8 result bits MSB first on SCLK
// falling edges. Pen-down interrupt follows Touch_I while idle with
// power-down mode 00.
module tp_adc_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [2:0]  X_ADDR      = 3'b101,
   parameter logic [2:0]  Y_ADDR      = 3'b001
) (
   input  logic                  Clock,
   input  logic                  Reset,
   tp_adc_responder_if.slave     tp,
   input  logic                  Touch_I,
   input  logic [11:0]           X_Value_I,
   input  logic [11:0]           Y_Value_I,
   output logic                  Cmd_Valid_O,
   output logic [7:0]            Cmd_O
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      BUSY = 2'd2,
      DATA = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] ss_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                   sclk_s;
   logic                   ss_s;
   logic                   mosi_s;
   logic                   sclk_d;
   logic                   ss_d;
   logic                   sclk_rise;
   logic                   sclk_fall;
   logic                   ss_fall;
   logic                   ss_rise;

   state_t                 state;
   logic [6:0]             cmd_sr;
   logic [3:0]             bit_cnt;
   logic [3:0]             data_cnt;
   logic [11:0]            data_sr;
   logic                   mode_r;
   logic [1:0]             pd_r;
   logic [7:0]             cmd_q;
   logic                   cmd_valid_q;
   logic                   miso_q;
   logic                   busy_q;
   logic                   penirq_q;

   logic [7:0]             cmd_byte;
   logic [11:0]            snap;
   logic [3:0]             last_cnt;

   // Input synchronisers; SCLK/SS_N idle high, MOSI idles low.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sclk_sync <= '1;
         ss_sync   <= '1;
         mosi_sync <= '0;
      end else begin
         sclk_sync <= SYNC_STAGES'({sclk_sync, tp.TP_SCLK_I});
         ss_sync   <= SYNC_STAGES'({ss_sync, tp.TP_SS_N_I});
         mosi_sync <= SYNC_STAGES'({mosi_sync, tp.TP_MOSI_I});
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];

   // Delayed copies of the synchronised levels for edge detection.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         sclk_d <= 1'b1;
         ss_d   <= 1'b1;
      end else begin
         sclk_d <= sclk_s;
         ss_d   <= ss_s;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_fall   = ~ss_s & ss_d;
   assign ss_rise   = ss_s & ~ss_d;

   // Full command byte as seen on the 8th rising edge, result selection
   // and number of data bits for the stored mode.
   always_comb begin
      cmd_byte = {cmd_sr, mosi_s};
      snap     = 12'h000;
      if (cmd_byte[6:4] == X_ADDR) begin
         snap = X_Value_I;
      end else if (cmd_byte[6:4] == Y_ADDR) begin
         snap = Y_Value_I;
      end
      last_cnt = mode_r ? 4'd8 : 4'd12;
   end

   // Transaction FSM with registered serial outputs and pen interrupt.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         cmd_sr      <= '0;
         bit_cnt     <= '0;
         data_cnt    <= '0;
         data_sr     <= '0;
         mode_r      <= 1'b0;
         pd_r        <= 2'b00;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         miso_q      <= 1'b0;
         busy_q      <= 1'b0;
         penirq_q    <= 1'b1;
      end else begin
         cmd_valid_q <= 1'b0;
         penirq_q    <= (state == IDLE && pd_r == 2'b00) ? ~Touch_I : 1'b1;
         // Deselect wins over any SCLK edge detected in the same cycle.
         if (ss_rise) begin
            state    <= IDLE;
            miso_q   <= 1'b0;
            busy_q   <= 1'b0;
            bit_cnt  <= '0;
            data_cnt <= '0;
            cmd_sr   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (ss_fall) begin
                     state   <= CMD;
                     bit_cnt <= '0;
                     cmd_sr  <= '0;
                  end
               end
               CMD: begin
                  if (sclk_rise && bit_cnt < 4'd8) begin
                     if (bit_cnt != 4'd0 || mosi_s) begin
                        cmd_sr  <= {cmd_sr[5:0], mosi_s};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                           cmd_q       <= cmd_byte;
                           cmd_valid_q <= 1'b1;
                           mode_r      <= cmd_byte[3];
                           pd_r        <= cmd_byte[1:0];
                           data_sr     <= cmd_byte[3] ? {snap[11:4], 4'h0} : snap;
                        end
                     end
                  end else if (sclk_fall && bit_cnt == 4'd8) begin
                     busy_q <= 1'b1;
                     state  <= BUSY;
                  end
               end
               BUSY: begin
                  if (sclk_fall) begin
                     busy_q   <= 1'b0;
                     miso_q   <= data_sr[11];
                     data_sr  <= {data_sr[10:0], 1'b0};
                     data_cnt <= 4'd1;
                     state    <= DATA;
                  end
               end
               DATA: begin
                  if (sclk_fall) begin
                     if (data_cnt == last_cnt) begin
                        miso_q   <= 1'b0;
                        state    <= CMD;
                        bit_cnt  <= '0;
                        data_cnt <= '0;
                     end else begin
                        miso_q   <= data_sr[11];
                        data_sr  <= {data_sr[10:0], 1'b0};
                        data_cnt <= data_cnt + 4'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign tp.TP_MISO_O     = miso_q;
   assign tp.TP_BUSY_O     = busy_q;
   assign tp.TP_PENIRQ_N_O = penirq_q;
   assign Cmd_Valid_O      = cmd_valid_q;
   assign Cmd_O            = cmd_q;

endmodule

// File: tb/tb_tp_adc_responder.sv
// Self-checking bench for tp_adc_responder: drives the serial link as a
// panel controller, predicts MISO bits into a scoreboard queue when each
// command is sent and pops them as the bits are read back.
module tb_tp_adc_responder;
   localparam int SYNC = 2;
   localparam int HALF = 6;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Touch_I;
   logic [11:0] X_Value_I;
   logic [11:0] Y_Value_I;
   logic        Cmd_Valid_O;
   logic [7:0]  Cmd_O;

   tp_adc_responder_if tp ();

   tp_adc_responder #(
      .SYNC_STAGES (SYNC),
      .X_ADDR      (3'b101),
      .Y_ADDR      (3'b001)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .tp          (tp),
      .Touch_I     (Touch_I),
      .X_Value_I   (X_Value_I),
      .Y_Value_I   (Y_Value_I),
      .Cmd_Valid_O (Cmd_Valid_O),
      .Cmd_O       (Cmd_O)
   );

   always #5 Clock = ~Clock;

   int   checks = 0;
   int   failures = 0;
   int   valid_pulses = 0;
   int   busy_cycles = 0;
   logic exp_q[$];
   logic miso_s;
   logic busy_s;

   // Count Cmd_Valid_O pulses and BUSY-high cycles.
   always @(negedge Clock) begin
      if (Cmd_Valid_O) valid_pulses++;
      if (tp.TP_BUSY_O) busy_cycles++;
   end

   // One SCLK period: MOSI set, low phase, sample MISO/BUSY, high phase.
   task automatic sclk_bit(input logic mosi);
      tp.TP_MOSI_I = mosi;
      repeat (HALF) @(negedge Clock);
      miso_s = tp.TP_MISO_O;
      busy_s = tp.TP_BUSY_O;
      tp.TP_SCLK_I = 1'b1;
      repeat (HALF) @(negedge Clock);
      tp.TP_SCLK_I = 1'b0;
   endtask

   task automatic send_cmd(input logic [7:0] c, input int zeros);
      for (int i = 0; i < zeros; i++) sclk_bit(1'b0);
      for (int i = 0; i < 8; i++) sclk_bit(c[7-i]);
   endtask

   task automatic push_exp(input logic [11:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v[11-i]);
   endtask

   task automatic ss_low();
      tp.TP_SS_N_I = 1'b0;
      repeat (HALF) @(negedge Clock);
   endtask

   task automatic ss_high();
      tp.TP_SS_N_I = 1'b1;
      repeat (HALF) @(negedge Clock);
   endtask

   task automatic test_reset();
      int n;
      Reset = 1'b1;
      tp.TP_SCLK_I = 1'b0;
      tp.TP_SS_N_I = 1'b1;
      tp.TP_MOSI_I = 1'b0;
      Touch_I   = 1'b1;
      X_Value_I = 12'h000;
      Y_Value_I = 12'h000;
      repeat (3) @(negedge Clock);
      checks++;
      if ({tp.TP_MISO_O, tp.TP_BUSY_O, tp.TP_PENIRQ_N_O, Cmd_Valid_O, Cmd_O} !== {4'b0010, 8'h00}) begin
         failures++;
         $display("FAIL reset_outputs: got %b required %b",
                  {tp.TP_MISO_O, tp.TP_BUSY_O, tp.TP_PENIRQ_N_O, Cmd_Valid_O, Cmd_O}, {4'b0010, 8'h00});
      end
      Reset = 1'b0;
      n = 0;
      while (tp.TP_PENIRQ_N_O !== 1'b0 && n < 10) begin
         @(negedge Clock);
         n++;
      end
      checks++;
      if (tp.TP_PENIRQ_N_O !== 1'b0 || n > SYNC + 2) begin
         failures++;
         $display("FAIL penirq_touch: got %b after %0d cycles required 0 within %0d", tp.TP_PENIRQ_N_O, n, SYNC + 2);
      end
      Touch_I = 1'b0;
      repeat (3) @(negedge Clock);
      checks++;
      if (tp.TP_PENIRQ_N_O !== 1'b1) begin
         failures++;
         $display("FAIL penirq_release: got %b required 1", tp.TP_PENIRQ_N_O);
      end
   endtask

   // Complete transaction: command, BUSY period, nbits data, trailing zeros.
   task automatic test_full_xfer(input logic [7:0] c, input logic [11:0] v, input int nbits, input int zeros);
      logic e;
      ss_low();
      valid_pulses = 0;
      push_exp(v, nbits);
      send_cmd(c, zeros);
      checks++;
      if (valid_pulses != 1 || Cmd_O !== c) begin
         failures++;
         $display("FAIL xfer_cmd: got pulses=%0d cmd=%h required pulses=1 cmd=%h", valid_pulses, Cmd_O, c);
      end
      busy_cycles = 0;
      sclk_bit(1'b0);
      checks++;
      if (busy_s !== 1'b1 || miso_s !== 1'b0) begin
         failures++;
         $display("FAIL xfer_busy_phase: got busy=%b miso=%b required busy=1 miso=0", busy_s, miso_s);
      end
      for (int i = 0; i < nbits; i++) begin
         sclk_bit(1'b0);
         e = exp_q.pop_front();
         checks++;
         if (miso_s !== e || busy_s !== 1'b0) begin
            failures++;
            $display("FAIL xfer_bit%0d cmd %h: got miso=%b busy=%b required miso=%b busy=0", i, c, miso_s, busy_s, e);
         end
      end
      for (int i = 0; i < 2; i++) begin
         sclk_bit(1'b0);
         checks++;
         if (miso_s !== 1'b0) begin
            failures++;
            $display("FAIL xfer_tail%0d: got miso=%b required 0", i, miso_s);
         end
      end
      checks++;
      if (busy_cycles != 2 * HALF) begin
         failures++;
         $display("FAIL xfer_busy_len: got %0d cycles required %0d", busy_cycles, 2 * HALF);
      end
      ss_high();
   endtask

   task automatic test_snapshot();
      logic e;
      X_Value_I = 12'h3F1;
      ss_low();
      push_exp(12'h3F1, 12);
      send_cmd(8'hD0, 0);
      sclk_bit(1'b0);
      for (int i = 0; i < 12; i++) begin
         sclk_bit(1'b0);
         if (i == 2) X_Value_I = 12'h000;
         e = exp_q.pop_front();
         checks++;
         if (miso_s !== e) begin
            failures++;
            $display("FAIL snapshot_bit%0d: got %b required %b", i, miso_s, e);
         end
      end
      ss_high();
   endtask

   task automatic test_abort();
      logic e;
      Touch_I   = 1'b1;
      Y_Value_I = 12'h6C9;
      ss_low();
      checks++;
      if (tp.TP_PENIRQ_N_O !== 1'b1) begin
         failures++;
         $display("FAIL abort_penirq_busy: got %b required 1", tp.TP_PENIRQ_N_O);
      end
      valid_pulses = 0;
      push_exp(12'h6C9, 12);
      send_cmd(8'h90, 3);
      checks++;
      if (valid_pulses != 1 || Cmd_O !== 8'h90) begin
         failures++;
         $display("FAIL abort_cmd: got pulses=%0d cmd=%h required pulses=1 cmd=90", valid_pulses, Cmd_O);
      end
      sclk_bit(1'b0);
      for (int i = 0; i < 5; i++) begin
         sclk_bit(1'b0);
         e = exp_q.pop_front();
         checks++;
         if (miso_s !== e) begin
            failures++;
            $display("FAIL abort_bit%0d: got %b required %b", i, miso_s, e);
         end
      end
      exp_q.delete();
      // SS_N rises together with the last SCLK fall.
      ss_high();
      repeat (2) @(negedge Clock);
      checks++;
      if ({tp.TP_BUSY_O, tp.TP_MISO_O, tp.TP_PENIRQ_N_O, Cmd_O} !== {3'b000, 8'h90}) begin
         failures++;
         $display("FAIL abort_idle: got busy,miso,penirq,cmd=%b required %b",
                  {tp.TP_BUSY_O, tp.TP_MISO_O, tp.TP_PENIRQ_N_O, Cmd_O}, {3'b000, 8'h90});
      end
      Touch_I = 1'b0;
   endtask

   task automatic test_penirq_pd();
      Touch_I = 1'b1;
      ss_low();
      send_cmd(8'h91, 0);
      ss_high();
      repeat (4) @(negedge Clock);
      checks++;
      if (tp.TP_PENIRQ_N_O !== 1'b1 || Cmd_O !== 8'h91) begin
         failures++;
         $display("FAIL pd01_penirq: got penirq=%b cmd=%h required penirq=1 cmd=91", tp.TP_PENIRQ_N_O, Cmd_O);
      end
      Y_Value_I = 12'hA5C;
      test_full_xfer(8'h90, 12'hA5C, 12, 0);
      repeat (2) @(negedge Clock);
      checks++;
      if (tp.TP_PENIRQ_N_O !== 1'b0) begin
         failures++;
         $display("FAIL pd00_penirq: got %b required 0", tp.TP_PENIRQ_N_O);
      end
      Touch_I = 1'b0;
   endtask

   task automatic test_reset_mid();
      ss_low();
      send_cmd(8'hD0, 0);
      repeat (5) @(negedge Clock);
      checks++;
      if (tp.TP_BUSY_O !== 1'b1) begin
         failures++;
         $display("FAIL mid_busy_pre: got %b required 1", tp.TP_BUSY_O);
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if ({tp.TP_MISO_O, tp.TP_BUSY_O, tp.TP_PENIRQ_N_O, Cmd_Valid_O, Cmd_O} !== {4'b0010, 8'h00}) begin
         failures++;
         $display("FAIL mid_reset_async: got %b required %b",
                  {tp.TP_MISO_O, tp.TP_BUSY_O, tp.TP_PENIRQ_N_O, Cmd_Valid_O, Cmd_O}, {4'b0010, 8'h00});
      end
      tp.TP_SS_N_I = 1'b1;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      repeat (4) @(negedge Clock);
      valid_pulses = 0;
      send_cmd(8'h90, 0);
      checks++;
      if (valid_pulses != 0 || Cmd_O !== 8'h00) begin
         failures++;
         $display("FAIL mid_no_select: got pulses=%0d cmd=%h required pulses=0 cmd=00", valid_pulses, Cmd_O);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      Y_Value_I = 12'hA5C;
      test_full_xfer(8'h90, 12'hA5C, 12, 0);
      test_snapshot();
      X_Value_I = 12'hC3A;
      test_full_xfer(8'hD8, 12'hC3A, 8, 0);
      test_abort();
      test_full_xfer(8'h90, 12'h6C9, 12, 0);
      test_penirq_pd();
      test_reset_mid();
      X_Value_I = 12'h5E7;
      test_full_xfer(8'hD0, 12'h5E7, 12, 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
